mnist_eval_sequencer: RTL
=========================

# mnist_eval_sequencer

Parametrised hardware sample sequencer and scoreboard for the pseudo-linear Boolean learner. It walks sample indices over a label ROM and drives the learner's `x`/`y` inputs, in either train mode (multi-epoch) or test mode. In test mode it compares the learner's `result` against the pipeline-aligned label and counts correct predictions. It moves accuracy accounting out of the bench and into synthesizable logic; software computes accuracy as correct_cnt/total_cnt.

## Interface
- `ADDR_W`, 14: sample index width; up to 2^ADDR_W samples.
- `EPOCH_W`, 8: epoch counter width.
- `RES_LAT`, 2: cycles from `x_valid_o` to a valid `result_i` (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: begin a run; sampled only in IDLE.
- `mode_i` in 1: 0 = TRAIN, 1 = TEST; latched at start.
- `count_i` in ADDR_W+1: samples per pass; latched at start.
- `epochs_i` in EPOCH_W: passes in TRAIN (0 is treated as 1); ignored in TEST.
- `abort_i` in 1: cancel an active run.
- `addr_o` out ADDR_W: label ROM address.
- `label_i` in 1: ROM data; valid 1 cycle after `addr_o` (synchronous ROM).
- `x_o` out ADDR_W: sample index to the learner.
- `x_valid_o` out 1: `x_o` is valid this cycle.
- `y_o` out 1: training label; 0 in TEST.
- `y_valid_o` out 1: high with `x_valid_o` in TRAIN only.
- `result_i` in 1: learner prediction.
- `busy_o` out 1: state is not IDLE.
- `done_o` out 1: one-cycle pulse at run completion.
- `correct_cnt_o` out ADDR_W+1: matches in TEST.
- `total_cnt_o` out ADDR_W+1: comparisons made in TEST.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `start_i`:
  - Latch mode, count and epochs.
  - Clear both counters, `addr`, and the epoch counter.
- IDLE → DONE when `start_i` arrives with `count_i`=0. Counters stay 0.
- RUN:
  - `addr_o` increments every cycle, and address-issue is high.
  - At `count-1`: if this is the last epoch, go to DRAIN. Otherwise `addr_o` wraps to 0 and the epoch counter increments. There is no bubble at the wrap.
- Stage 1, the register stage:
  - `x_o` takes the previous cycle's address and `x_valid_o` the previous address-issue.
  - `y_o` = `label_i` in TRAIN.
- Stage 2, the compare stage (TEST only):
  - `label_i` and `x_valid_o` are delayed RES_LAT cycles.
  - When the delayed valid is high: `total_cnt` += 1, and `correct_cnt` += 1 if `result_i` == delayed label.
- DRAIN:
  - Wait until the pipeline valids are empty: 1 cycle in TRAIN, RES_LAT+1 cycles in TEST.
  - Then go to DONE.
- DONE: `done_o`=1 for one cycle, then IDLE. Counters hold until the next start.
- `abort_i` in RUN or DRAIN:
  - Next state is IDLE, with no `done_o`.
  - All pipeline valids are cleared the same edge, and counters freeze.
  - abort has priority over any other transition.
- `start_i` outside IDLE is ignored.
- Counters cannot overflow, because total ≤ 2^ADDR_W fits in ADDR_W+1 bits.

## Timing
- Reset: all outputs are 0, the FSM is in IDLE, and the valid pipeline is cleared.
- `start_i` sampled at edge T0:
  - First `addr_o` valid in cycle T1.
  - `x_o`/`y_o` valid in T2.
- TEST:
  - Sample k is compared in cycle T(k+2+RES_LAT).
  - `done_o` in T(count+RES_LAT+2).
- TRAIN: `done_o` in T(count·E+2), where E = max(epochs, 1).
- `count_i`=0: `done_o` in T1.
- `rst` mid-run overrides everything and returns the block to the reset state on the next edge.

## Structure
- `mnist_eval_pkg` holds:
  - The state enum (`IDLE`/`RUN`/`DRAIN`/`DONE`).
  - The mode enum (`MODE_TRAIN`/`MODE_TEST`).
  - The default localparams.
- Sub-module `label_delay_line`, parametrised by DEPTH=RES_LAT: a 2-bit shift register {valid, label} with a synchronous clear used by reset and abort.
- The top level contains the FSM, address/epoch counters, stage-1 registers and the scoreboard counters.

## Test plan
- TEST, RES_LAT=2, count=4, labels 1,0,1,1, results 1,1,1,0 → correct=2, total=4, `done_o` in T8, `busy_o` high T1–T8.
- TRAIN, count=3, epochs=2 → `addr_o` 0,1,2,0,1,2 with no gap, `y_o` equals labels, `done_o` in T8, counters stay 0.
- count=0 with start → `done_o` in T1, counters 0, `x_valid_o` never high.
- abort in the 3rd RUN cycle of a TEST with count=8 → IDLE next edge, no `done_o`, `x_valid_o` low within 1 cycle, total ≤ 1 and frozen.
- `start_i` pulsed during RUN, and `rst` asserted mid-DRAIN → the start is ignored; after reset all outputs are 0 and a new start proceeds normally.
- TEST, count=2^ADDR_W with all results matching → correct = total = 2^ADDR_W, with no wrap.

Source files
------------

// File: rtl/mnist_eval_pkg.sv
// Shared types and default sizing for the MNIST evaluation sequencer.
package mnist_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_TRAIN = 1'b0,
    MODE_TEST  = 1'b1
  } mode_e;

  localparam int DEF_ADDR_W  = 14;
  localparam int DEF_EPOCH_W = 8;
  localparam int DEF_RES_LAT = 2;

endpackage

// File: rtl/label_delay_line.sv
// Fixed-depth {valid, label} shift register that aligns labels with learner results.
module label_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic i_clear,
  input  logic i_valid,
  input  logic i_label,
  output logic o_valid,
  output logic o_label
);

  logic [1:0] r_stage [DEPTH];

  // Clear wipes every stage so an aborted run cannot leak compares into the next one.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= 2'b00;
      end
    end else begin
      r_stage[0] <= {i_valid, i_label};
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_valid = r_stage[DEPTH-1][1];
  assign o_label = r_stage[DEPTH-1][0];

endmodule

// File: rtl/mnist_eval_sequencer.sv
// Sample sequencer and accuracy scoreboard for the pseudo-linear Boolean learner.
module mnist_eval_sequencer
  import mnist_eval_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int EPOCH_W = DEF_EPOCH_W,
  parameter int RES_LAT = DEF_RES_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [ADDR_W:0]    count_i,
  input  logic [EPOCH_W-1:0] epochs_i,
  input  logic               abort_i,
  output logic [ADDR_W-1:0]  addr_o,
  input  logic               label_i,
  output logic [ADDR_W-1:0]  x_o,
  output logic               x_valid_o,
  output logic               y_o,
  output logic               y_valid_o,
  input  logic               result_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [ADDR_W:0]    correct_cnt_o,
  output logic [ADDR_W:0]    total_cnt_o
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;
  localparam int DRAIN_W = $clog2(RES_LAT + 1) + 1;

  logic [1:0]         r_state;
  mode_e              r_mode;
  logic [ADDR_W:0]    r_countM1;
  logic [EPOCH_W-1:0] r_epochLast;
  logic [EPOCH_W-1:0] r_epoch;
  logic [ADDR_W-1:0]  r_addr;
  logic [DRAIN_W-1:0] r_drain;
  logic [ADDR_W-1:0]  r_x;
  logic               r_xValid;
  logic [ADDR_W:0]    r_correct;
  logic [ADDR_W:0]    r_total;

  logic               w_active;
  logic               w_abort;
  logic               w_issue;
  logic               w_lastAddr;
  logic               w_lastEpoch;
  logic [DRAIN_W-1:0] w_drainLen;
  logic               w_drainLast;
  logic               w_dlyValid;
  logic               w_dlyLabel;

  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_abort     = abort_i && w_active;
  assign w_issue     = (r_state == S_RUN);
  assign w_lastAddr  = ({1'b0, r_addr} == r_countM1);
  assign w_lastEpoch = (r_mode == MODE_TEST) || (r_epoch == r_epochLast);
  // TEST must also wait out the result latency before the last compare lands.
  assign w_drainLen  = (r_mode == MODE_TEST) ? DRAIN_W'(RES_LAT) : '0;
  assign w_drainLast = (r_drain == w_drainLen);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= MODE_TRAIN;
      r_countM1   <= '0;
      r_epochLast <= '0;
      r_epoch     <= '0;
      r_addr      <= '0;
      r_drain     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mode      <= mode_e'(mode_i);
            r_countM1   <= count_i - 1'b1;
            r_epochLast <= (epochs_i == '0) ? '0 : epochs_i - 1'b1;
            r_epoch     <= '0;
            r_addr      <= '0;
            r_drain     <= '0;
            r_state     <= (count_i == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (w_lastAddr) begin
            if (w_lastEpoch) begin
              r_state <= S_DRAIN;
            end else begin
              r_addr  <= '0;
              r_epoch <= r_epoch + 1'b1;
            end
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (w_drainLast) begin
            r_state <= S_DONE;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stage 1: the ROM answers one cycle after the address, so x/valid lag by one too.
  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      r_x      <= '0;
      r_xValid <= 1'b0;
    end else begin
      r_x      <= r_addr;
      r_xValid <= w_issue;
    end
  end

  label_delay_line #(
    .DEPTH (RES_LAT)
  ) u_labelDelay (
    .clk     (clk),
    .i_clear (rst || w_abort),
    .i_valid (r_xValid && (r_mode == MODE_TEST)),
    .i_label (label_i),
    .o_valid (w_dlyValid),
    .o_label (w_dlyLabel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_correct <= '0;
      r_total   <= '0;
    end else if ((r_state == S_IDLE) && start_i) begin
      r_correct <= '0;
      r_total   <= '0;
    end else if (!w_abort && w_dlyValid) begin
      r_total <= r_total + 1'b1;
      if (result_i == w_dlyLabel) begin
        r_correct <= r_correct + 1'b1;
      end
    end
  end

  assign addr_o        = r_addr;
  assign x_o           = r_x;
  assign x_valid_o     = r_xValid;
  assign y_valid_o     = r_xValid && (r_mode == MODE_TRAIN);
  assign y_o           = y_valid_o && label_i;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);
  assign correct_cnt_o = r_correct;
  assign total_cnt_o   = r_total;

endmodule
